decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS32 pipeline. Consumes the IF/ID register outputs from fetch and produces the ID/EX pipeline register.
- Contains the register file with write-back port, main control decode, and load-use/branch hazard detection. Hazard detection drives the fetch hold inputs.
- Resolves beq/j in ID and drives the next PC to fetch. The wrong-path instruction is squashed one cycle later.

Parameters:
- RF_DEPTH, 32, number of architectural registers; $0 is hardwired to zero.
- IDEX_W, 151, ID/EX payload width: pc4 32 + rs data 32 + rt data 32 + imm 32 + rs/rt/rd 15 + control 8.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- IF_ID_PC_plus4  in  32  PC+4 of the instruction in ID
- IF_ID_Instruction  in  32  instruction in ID
- PC_OUT_plus4  in  32  fetch-side PC+4, the sequential next PC
- WB_RegWrite  in  1  write-back enable
- WB_WriteReg  in  5  write-back destination
- WB_WriteData  in  32  write-back data
- EX_MEM_MemRead  in  1  load in MEM stage
- EX_MEM_WriteReg  in  5  MEM-stage destination
- pc_next  out  32  next PC to fetch pc_in
- HoldPC  out  1  freeze PC
- Hold_data  out  1  freeze IF/ID register
- ID_EX_out  out  IDEX_W  registered ID/EX payload
- ID_EX_MemRead  out  1  registered
- ID_EX_RegWrite  out  1  registered
- ID_EX_WriteReg  out  5  registered; rd if RegDst, else rt

Behaviour:
- Clock and reset:
  - One clock domain.
  - Synchronous active-high reset clears all 31 registers, the ID/EX register (a NOP: all control 0), and squash_q.
  - After reset, pc_next = PC_OUT_plus4 and HoldPC = Hold_data = 0.
- Decoded ops:
  - R-type (op 0, funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A): RegDst=1, RegWrite=1, ALUOp=10.
  - lw 0x23: ALUSrc, MemRead, MemtoReg, RegWrite, ALUOp=00.
  - sw 0x2B: ALUSrc, MemWrite, ALUOp=00.
  - addi 0x08: ALUSrc, RegWrite, ALUOp=00.
  - beq 0x04 and j 0x02: no EX-side control.
  - Unknown opcodes are treated as NOP, with all control 0.
- Immediate: sign-extended imm16.
- Register file:
  - 2 combinational read ports and 1 write port on posedge when WB_RegWrite and WB_WriteReg != 0.
  - Writes to $0 are ignored; reads of $0 return 0.
  - Internal write-through: a same-cycle write to the address being read returns WB_WriteData.
- Squash:
  - squash_q is set at the posedge when a taken beq or j is accepted (not stalled); otherwise it is cleared.
  - While squash_q = 1, the IF/ID instruction is treated as NOP. It cannot stall and cannot branch.
- Stall, combinational (stall forces HoldPC = Hold_data = 1):
  - Load-use: ID_EX_MemRead and ID_EX_WriteReg != 0 and it equals rs, or equals rt where rt is a source (R-type, sw, beq).
  - Branch-EX: the current instruction is beq, ID_EX_RegWrite is set, and ID_EX_WriteReg != 0 matches rs or rt.
  - Branch-MEM: the current instruction is beq, EX_MEM_MemRead is set, and EX_MEM_WriteReg != 0 matches rs or rt.
- Effect of a stall:
  - pc_next = PC_OUT_plus4; the value is don't-care because the PC is held.
  - The ID/EX register loads a bubble (all control 0).
  - No branch is taken.
- Branch and jump:
  - beq is taken when the two RF read values are equal: pc_next = IF_ID_PC_plus4 + (imm << 2).
  - j: pc_next = {IF_ID_PC_plus4[31:28], instr[25:0], 2'b00}.
  - Otherwise pc_next = PC_OUT_plus4.
  - Branch operands come only from the RF and its write-through. Hazards that forwarding would resolve are stalled instead.
- Latency: ID/EX outputs are valid one cycle after the instruction appears on IF_ID_Instruction, provided there is no stall.
- Simultaneous events:
  - Stall has priority over branch.
  - Squash has priority over stall.
  - Reset has priority over everything.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct constants
  - ALUOp encodings
  - the ID/EX field offsets
- Natural sub-modules:
  - register_file (32x32, write-through)
  - the existing pipeline_register #(IDEX_W), with Hold_data tied 0; bubbles are inserted by muxing zero control.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles while instruction = add $3,$1,$2.
  - Response: ID_EX control = 0, HoldPC = 0, pc_next = PC_OUT_plus4.
- Write-through:
  - Stimulus: WB writes $5 = 0x1234 while ID decodes addi $6,$5,7.
  - Response: next cycle, ID_EX rs data = 0x1234 and imm = 0x00000007.
- Load-use:
  - Stimulus: ID_EX holds lw to $4 while ID decodes sub $7,$4,$1.
  - Response: HoldPC = Hold_data = 1 for one cycle and a bubble is inserted. The following cycle, sub issues normally.
- Taken beq:
  - Stimulus: $1 = $2 = 9, IF_ID_PC_plus4 = 0x100, imm = 0xFFFE.
  - Response: pc_next = 0xF8. Next cycle, the IF/ID instruction is squashed: ID_EX control = 0 and no stall even if it matches a hazard.
- Jump:
  - Stimulus: j 0x0000040 at IF_ID_PC_plus4 = 0x00400008.
  - Response: pc_next = 0x00000100, then a squash.
- Branch-MEM stall:
  - Stimulus: beq $8,$0 with EX_MEM_MemRead = 1 and EX_MEM_WriteReg = 8.
  - Response: one-cycle stall with no branch. The branch resolves after WB writes $8.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 decode constants: opcodes, functs, ALUOp encodings and the
// ID/EX payload field layout used by the decode stage and its consumers.
package mips_pkg;

    localparam int RF_DEPTH = 32;
    localparam int IDEX_W   = 151;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10
    } aluop_e;

    // Control byte, MSB first: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite ALUOp[1:0]
    typedef struct packed {
        logic   reg_dst;
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        aluop_e alu_op;
    } ctrl_t;

    localparam int CTRL_W        = 8;
    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMREAD  = 3;

    // ID/EX payload, LSB first: ctrl, rd, rt, rs, imm, rt data, rs data, pc+4
    localparam int IDEX_CTRL_LSB = 0;
    localparam int IDEX_RD_LSB   = 8;
    localparam int IDEX_RT_LSB   = 13;
    localparam int IDEX_RS_LSB   = 18;
    localparam int IDEX_IMM_LSB  = 23;
    localparam int IDEX_RTD_LSB  = 55;
    localparam int IDEX_RSD_LSB  = 87;
    localparam int IDEX_PC4_LSB  = 119;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/pipeline_register.sv
// Generic pipeline register with hold; synchronous reset clears to zero.
module pipeline_register #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = hold ? q_q : d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through,
// one synchronous write port; $0 reads as zero and ignores writes.
module register_file #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr_a,
    output logic [31:0]   rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [31:0]   rdata_b,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] regs_q [DEPTH];
    logic [31:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (we && waddr != '0) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        if (raddr_a == '0)                   rdata_a = '0;
        else if (we && waddr == raddr_a)     rdata_a = wdata;
        else                                 rdata_a = regs_q[raddr_a];

        if (raddr_b == '0)                   rdata_b = '0;
        else if (we && waddr == raddr_b)     rdata_b = wdata;
        else                                 rdata_b = regs_q[raddr_b];
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS32 ID stage: register file, main control decode, load-use/branch
// hazard stalls, beq/j resolution with one-cycle wrong-path squash.
module decode_stage
    import mips_pkg::*;
#(
    parameter int RF_DEPTH = 32,
    parameter int IDEX_W   = 151
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       IF_ID_PC_plus4,
    input  logic [31:0]       IF_ID_Instruction,
    input  logic [31:0]       PC_OUT_plus4,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_WriteReg,
    input  logic [31:0]       WB_WriteData,
    input  logic              EX_MEM_MemRead,
    input  logic [4:0]        EX_MEM_WriteReg,
    output logic [31:0]       pc_next,
    output logic              HoldPC,
    output logic              Hold_data,
    output logic [IDEX_W-1:0] ID_EX_out,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_RegWrite,
    output logic [4:0]        ID_EX_WriteReg
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    logic        squash_q;
    logic        squash_d;

    ctrl_t       ctrl;
    ctrl_t       ctrl_issue;
    logic        is_beq;
    logic        is_j;
    logic        rt_src;
    logic        load_use;
    logic        br_ex;
    logic        br_mem;
    logic        stall;
    logic        taken;
    logic [IDEX_W-1:0] idex_d;

    assign opcode = IF_ID_Instruction[31:26];
    assign rs     = IF_ID_Instruction[25:21];
    assign rt     = IF_ID_Instruction[20:16];
    assign rd     = IF_ID_Instruction[15:11];
    assign funct  = IF_ID_Instruction[5:0];
    assign imm    = sign_ext16(IF_ID_Instruction[15:0]);

    register_file #(
        .DEPTH (RF_DEPTH),
        .AW    (5)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs),
        .rdata_a (rs_data),
        .raddr_b (rt),
        .rdata_b (rt_data),
        .we      (WB_RegWrite),
        .waddr   (WB_WriteReg),
        .wdata   (WB_WriteData)
    );

    // A squashed slot decodes as NOP, which also masks its stall and branch.
    always_comb begin
        ctrl   = '0;
        is_beq = 1'b0;
        is_j   = 1'b0;
        rt_src = 1'b0;
        if (!squash_q) begin
            case (opcode)
                OP_RTYPE: begin
                    if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                        funct == FN_OR  || funct == FN_SLT) begin
                        ctrl.reg_dst   = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.alu_op    = ALUOP_RTYPE;
                        rt_src         = 1'b1;
                    end
                end
                OP_LW: begin
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                end
                OP_SW: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    rt_src         = 1'b1;
                end
                OP_ADDI: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                OP_BEQ: begin
                    is_beq = 1'b1;
                    rt_src = 1'b1;
                end
                OP_J: begin
                    is_j = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_use = ID_EX_MemRead && ID_EX_WriteReg != '0 &&
                   (ID_EX_WriteReg == rs || (rt_src && ID_EX_WriteReg == rt));
        br_ex    = is_beq && ID_EX_RegWrite && ID_EX_WriteReg != '0 &&
                   (ID_EX_WriteReg == rs || ID_EX_WriteReg == rt);
        br_mem   = is_beq && EX_MEM_MemRead && EX_MEM_WriteReg != '0 &&
                   (EX_MEM_WriteReg == rs || EX_MEM_WriteReg == rt);
        stall    = !squash_q && (load_use || br_ex || br_mem);
        taken    = !stall && (is_j || (is_beq && rs_data == rt_data));
        squash_d = taken;

        if (taken && is_j) begin
            pc_next = {IF_ID_PC_plus4[31:28], IF_ID_Instruction[25:0], 2'b00};
        end else if (taken) begin
            pc_next = IF_ID_PC_plus4 + {imm[29:0], 2'b00};
        end else begin
            pc_next = PC_OUT_plus4;
        end

        ctrl_issue = stall ? '0 : ctrl;
        idex_d     = {IF_ID_PC_plus4, rs_data, rt_data, imm, rs, rt, rd, ctrl_issue};
    end

    assign HoldPC    = stall;
    assign Hold_data = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            squash_q <= 1'b0;
        end else begin
            squash_q <= squash_d;
        end
    end

    pipeline_register #(
        .W (IDEX_W)
    ) u_idex (
        .clk  (clk),
        .rst  (rst),
        .hold (1'b0),
        .d    (idex_d),
        .q    (ID_EX_out)
    );

    assign ID_EX_MemRead  = ID_EX_out[IDEX_CTRL_LSB + CTRL_MEMREAD];
    assign ID_EX_RegWrite = ID_EX_out[IDEX_CTRL_LSB + CTRL_REGWRITE];
    assign ID_EX_WriteReg = ID_EX_out[IDEX_CTRL_LSB + CTRL_REGDST] ?
                            ID_EX_out[IDEX_RD_LSB +: 5] : ID_EX_out[IDEX_RT_LSB +: 5];

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: cycle-by-cycle vector table with a scoreboard
// queue for the registered ID/EX outputs, plus reset sequences.
module tb_decode_stage;
    import mips_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       IF_ID_PC_plus4;
    logic [31:0]       IF_ID_Instruction;
    logic [31:0]       PC_OUT_plus4;
    logic              WB_RegWrite;
    logic [4:0]        WB_WriteReg;
    logic [31:0]       WB_WriteData;
    logic              EX_MEM_MemRead;
    logic [4:0]        EX_MEM_WriteReg;
    logic [31:0]       pc_next;
    logic              HoldPC;
    logic              Hold_data;
    logic [IDEX_W-1:0] ID_EX_out;
    logic              ID_EX_MemRead;
    logic              ID_EX_RegWrite;
    logic [4:0]        ID_EX_WriteReg;

    decode_stage #(
        .RF_DEPTH (32),
        .IDEX_W   (151)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .IF_ID_PC_plus4    (IF_ID_PC_plus4),
        .IF_ID_Instruction (IF_ID_Instruction),
        .PC_OUT_plus4      (PC_OUT_plus4),
        .WB_RegWrite       (WB_RegWrite),
        .WB_WriteReg       (WB_WriteReg),
        .WB_WriteData      (WB_WriteData),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_WriteReg   (EX_MEM_WriteReg),
        .pc_next           (pc_next),
        .HoldPC            (HoldPC),
        .Hold_data         (Hold_data),
        .ID_EX_out         (ID_EX_out),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_RegWrite    (ID_EX_RegWrite),
        .ID_EX_WriteReg    (ID_EX_WriteReg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] if_pc4;
        logic        wb_we;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        mr;
        logic [4:0]  mreg;
        logic        seq;
        logic [31:0] exp_pc;
        logic        exp_hold;
        logic [7:0]  ctrl;
        logic        chk_wr;
        logic [4:0]  wr;
        logic        chk_data;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
    } vec_t;

    typedef struct {
        int          idx;
        logic [7:0]  ctrl;
        logic        chk_wr;
        logic [4:0]  wr;
        logic        chk_data;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [7:0] C_R    = 8'h92;
    localparam logic [7:0] C_LW   = 8'h78;
    localparam logic [7:0] C_SW   = 8'h44;
    localparam logic [7:0] C_ADDI = 8'h50;

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] i);
        return {op, s, t, i};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idex(input exp_t e);
        check($sformatf("v%0d ctrl", e.idx), 32'(ID_EX_out[IDEX_CTRL_LSB +: 8]), 32'(e.ctrl));
        check($sformatf("v%0d memread", e.idx), 32'(ID_EX_MemRead), 32'(e.ctrl[3]));
        check($sformatf("v%0d regwrite", e.idx), 32'(ID_EX_RegWrite), 32'(e.ctrl[4]));
        if (e.chk_wr)
            check($sformatf("v%0d writereg", e.idx), 32'(ID_EX_WriteReg), 32'(e.wr));
        if (e.chk_data) begin
            check($sformatf("v%0d rs_data", e.idx), ID_EX_out[IDEX_RSD_LSB +: 32], e.rs_d);
            check($sformatf("v%0d rt_data", e.idx), ID_EX_out[IDEX_RTD_LSB +: 32], e.rt_d);
            check($sformatf("v%0d imm", e.idx), ID_EX_out[IDEX_IMM_LSB +: 32], e.imm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;
        logic [31:0] nop, addi_w, lw4, sub7, beq12, beq33, j40, addi9, sw2;
        logic [31:0] beq82, lw10, add11, beq110, or12, and13, unk, slt14, addin;
        nop    = 32'h0;
        addi_w = enc_i(OP_ADDI, 5'd5, 5'd6, 16'h0007);
        lw4    = enc_i(OP_LW, 5'd1, 5'd4, 16'h0000);
        sub7   = enc_r(5'd4, 5'd1, 5'd7, 6'h22);
        beq12  = enc_i(OP_BEQ, 5'd1, 5'd2, 16'hFFFE);
        beq33  = enc_i(OP_BEQ, 5'd3, 5'd3, 16'h0001);
        j40    = {6'h02, 26'h0000040};
        addi9  = enc_i(OP_ADDI, 5'd0, 5'd9, 16'h0005);
        sw2    = enc_i(OP_SW, 5'd1, 5'd2, 16'h0004);
        beq82  = enc_i(OP_BEQ, 5'd8, 5'd2, 16'h0003);
        lw10   = enc_i(OP_LW, 5'd8, 5'd10, 16'h0000);
        add11  = enc_r(5'd1, 5'd2, 5'd11, 6'h20);
        beq110 = enc_i(OP_BEQ, 5'd11, 5'd0, 16'h0010);
        or12   = enc_r(5'd0, 5'd1, 5'd12, 6'h25);
        and13  = enc_r(5'd0, 5'd0, 5'd13, 6'h24);
        unk    = enc_i(6'h3F, 5'd1, 5'd2, 16'h0000);
        slt14  = enc_r(5'd2, 5'd1, 5'd14, 6'h2A);
        addin  = enc_i(OP_ADDI, 5'd1, 5'd15, 16'h8000);

        //       instr   if_pc4        we wreg  wdata       mr mreg seq exp_pc        hold ctrl    cw wr    cd rs_d   rt_d   imm
        v = '{nop,    32'h10,       1, 5'd1, 32'd9,      0, 5'd0, 1, 32'h0,        0, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{nop,    32'h14,       1, 5'd2, 32'd9,      0, 5'd0, 1, 32'h0,        0, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{addi_w, 32'h18,       1, 5'd5, 32'h1234,   0, 5'd0, 1, 32'h0,        0, C_ADDI, 1, 5'd6,  1, 32'h1234, 32'd0, 32'h7}; tbl.push_back(v);
        v = '{lw4,    32'h1C,       0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, C_LW,   1, 5'd4,  1, 32'd9, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{sub7,   32'h20,       0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        1, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{sub7,   32'h20,       0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, C_R,    1, 5'd7,  1, 32'd0, 32'd9, 32'h3822}; tbl.push_back(v);
        v = '{beq12,  32'h100,      0, 5'd0, 32'd0,      0, 5'd0, 0, 32'hF8,       0, 8'h00,  0, 5'd0,  1, 32'd9, 32'd9, 32'hFFFFFFFE}; tbl.push_back(v);
        v = '{beq33,  32'h104,      0, 5'd0, 32'd0,      1, 5'd3, 1, 32'h0,        0, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{j40,    32'h00400008, 0, 5'd0, 32'd0,      0, 5'd0, 0, 32'h100,      0, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{addi9,  32'h10C,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{sw2,    32'h110,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, C_SW,   1, 5'd2,  1, 32'd9, 32'd9, 32'h4}; tbl.push_back(v);
        v = '{beq82,  32'h200,      0, 5'd0, 32'd0,      1, 5'd8, 1, 32'h0,        1, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{beq82,  32'h200,      1, 5'd8, 32'd9,      0, 5'd0, 0, 32'h20C,      0, 8'h00,  0, 5'd0,  1, 32'd9, 32'd9, 32'h3}; tbl.push_back(v);
        v = '{lw10,   32'h204,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{add11,  32'h2FC,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, C_R,    1, 5'd11, 1, 32'd9, 32'd9, 32'h5820}; tbl.push_back(v);
        v = '{beq110, 32'h300,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        1, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{beq110, 32'h300,      0, 5'd0, 32'd0,      0, 5'd0, 0, 32'h340,      0, 8'h00,  0, 5'd0,  1, 32'd0, 32'd0, 32'h10}; tbl.push_back(v);
        v = '{sw2,    32'h304,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{or12,   32'h308,      1, 5'd0, 32'hDEAD,   0, 5'd0, 1, 32'h0,        0, C_R,    1, 5'd12, 1, 32'd0, 32'd9, 32'h6025}; tbl.push_back(v);
        v = '{and13,  32'h30C,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, C_R,    1, 5'd13, 1, 32'd0, 32'd0, 32'h6824}; tbl.push_back(v);
        v = '{unk,    32'h310,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, 8'h00,  0, 5'd0,  0, 32'd0, 32'd0, 32'h0}; tbl.push_back(v);
        v = '{slt14,  32'h314,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, C_R,    1, 5'd14, 1, 32'd9, 32'd9, 32'h702A}; tbl.push_back(v);
        v = '{addin,  32'h318,      0, 5'd0, 32'd0,      0, 5'd0, 1, 32'h0,        0, C_ADDI, 1, 5'd15, 1, 32'd9, 32'd0, 32'hFFFF8000}; tbl.push_back(v);

        // Reset held for two cycles with a valid add in ID.
        rst               = 1'b1;
        IF_ID_Instruction = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        IF_ID_PC_plus4    = 32'h8;
        PC_OUT_plus4      = 32'h1000;
        WB_RegWrite       = 1'b0;
        WB_WriteReg       = '0;
        WB_WriteData      = '0;
        EX_MEM_MemRead    = 1'b0;
        EX_MEM_WriteReg   = '0;
        tick();
        tick();
        check("reset ctrl", 32'(ID_EX_out[IDEX_CTRL_LSB +: 8]), 32'h0);
        check("reset regwrite", 32'(ID_EX_RegWrite), 32'h0);
        check("reset holdpc", 32'(HoldPC), 32'h0);
        check("reset hold_data", 32'(Hold_data), 32'h0);
        check("reset pc_next", pc_next, 32'h1000);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            IF_ID_Instruction = v.instr;
            IF_ID_PC_plus4    = v.if_pc4;
            PC_OUT_plus4      = 32'h2000 + 32'(i) * 4;
            WB_RegWrite       = v.wb_we;
            WB_WriteReg       = v.wb_reg;
            WB_WriteData      = v.wb_data;
            EX_MEM_MemRead    = v.mr;
            EX_MEM_WriteReg   = v.mreg;
            e = '{i, v.ctrl, v.chk_wr, v.wr, v.chk_data, v.rs_d, v.rt_d, v.imm};
            sb.push_back(e);
            #3;
            check($sformatf("v%0d pc_next", i), pc_next, v.seq ? (32'h2000 + 32'(i) * 4) : v.exp_pc);
            check($sformatf("v%0d holdpc", i), 32'(HoldPC), 32'(v.exp_hold));
            check($sformatf("v%0d hold_data", i), 32'(Hold_data), 32'(v.exp_hold));
            tick();
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_idex(e);
            end else begin
                check($sformatf("v%0d scoreboard empty", i), 32'd0, 32'd1);
            end
        end

        // Reset mid-run over a taken jump: must clear ID/EX, squash and the RF.
        rst               = 1'b1;
        IF_ID_Instruction = {6'h02, 26'h0000040};
        IF_ID_PC_plus4    = 32'h00400008;
        WB_RegWrite       = 1'b0;
        EX_MEM_MemRead    = 1'b0;
        tick();
        tick();
        check("rerst ctrl", 32'(ID_EX_out[IDEX_CTRL_LSB +: 8]), 32'h0);
        check("rerst memread", 32'(ID_EX_MemRead), 32'h0);
        rst               = 1'b0;
        IF_ID_Instruction = enc_i(OP_ADDI, 5'd1, 5'd16, 16'h0001);
        PC_OUT_plus4      = 32'h3000;
        #3;
        check("post-rst pc_next", pc_next, 32'h3000);
        check("post-rst holdpc", 32'(HoldPC), 32'h0);
        tick();
        check("post-rst ctrl", 32'(ID_EX_out[IDEX_CTRL_LSB +: 8]), 32'(C_ADDI));
        check("post-rst rs_data", ID_EX_out[IDEX_RSD_LSB +: 32], 32'h0);
        check("post-rst writereg", 32'(ID_EX_WriteReg), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
